// File: rtl/cmp_pkg.sv
// Shared types for the digit-serial magnitude comparator.
// State encoding, digit width and the {eq,gt,lt} result bundle.
package cmp_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

  function automatic int idx_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit digit compare shared by every step of the scan.
// Exactly one of E/G/L is high for any input pair.
module cmp2_slice
  import cmp_pkg::*;
(
  input  logic [DIGIT_W-1:0] ad,
  input  logic [DIGIT_W-1:0] bd,
  output logic               E,
  output logic               G,
  output logic               L
);

  assign E = (ad == bd);
  assign G = (ad > bd);
  assign L = (ad < bd);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Unsigned WIDTH-bit compare walked MSB digit first, one digit per clock.
// One cmp2_slice is time-shared; FSM, operands and sticky flags live here.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int D     = WIDTH / DIGIT_W;
  localparam int IDX_W = idx_width(D);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(D - 1);

  cmp_state_e state_q, state_d;
  cmp_res_t   res_q, res_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             stk_vld_q, stk_gt_q, stk_lt_q;
  logic             accept, step;

  logic [DIGIT_W-1:0] ad, bd;
  logic               se, sg, sl;

  assign ad = a_q[{idx_q, 1'b0} +: DIGIT_W];
  assign bd = b_q[{idx_q, 1'b0} +: DIGIT_W];

  cmp2_slice u_slice (
    .ad (ad),
    .bd (bd),
    .E  (se),
    .G  (sg),
    .L  (sl)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!se && EARLY_EXIT) begin
          state_d = S_DONE;
          res_d   = cmp_res_t'{eq: 1'b0, gt: sg, lt: sl};
        end else if (idx_q == '0) begin
          state_d = S_DONE;
          // MSB-side difference already captured must win
          if (stk_vld_q)
            res_d = cmp_res_t'{eq: 1'b0, gt: stk_gt_q, lt: stk_lt_q};
          else if (!se)
            res_d = cmp_res_t'{eq: 1'b0, gt: sg, lt: sl};
          else
            res_d = cmp_res_t'{eq: 1'b1, gt: 1'b0, lt: 1'b0};
        end else begin
          step = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_COMPARE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept)
      res_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      res_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      stk_vld_q <= 1'b0;
      stk_gt_q  <= 1'b0;
      stk_lt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (accept) begin
        a_q       <= a;
        b_q       <= b;
        idx_q     <= IDX_TOP;
        stk_vld_q <= 1'b0;
        stk_gt_q  <= 1'b0;
        stk_lt_q  <= 1'b0;
      end else if (state_q == S_COMPARE) begin
        if (step)
          idx_q <= idx_q - IDX_W'(1);
        if (!se && !stk_vld_q) begin
          stk_vld_q <= 1'b1;
          stk_gt_q  <= sg;
          stk_lt_q  <= sl;
        end
      end
    end
  end

  assign busy = (state_q == S_COMPARE);
  assign done = (state_q == S_DONE);
  assign eq   = res_q.eq;
  assign gt   = res_q.gt;
  assign lt   = res_q.lt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: early-exit and full-scan instances
// driven in parallel and checked against an arithmetic reference.
module tb_seq_magnitude_comparator;

  localparam int W = 8;
  localparam int D = W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic [1:0]   busy_w, done_w, eq_w, gt_w, lt_w;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
    .clk (clk), .rst (rst), .start (start), .a (a), .b (b),
    .busy (busy_w[0]), .done (done_w[0]),
    .eq (eq_w[0]), .gt (gt_w[0]), .lt (lt_w[0])
  );

  seq_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
    .clk (clk), .rst (rst), .start (start), .a (a), .b (b),
    .busy (busy_w[1]), .done (done_w[1]),
    .eq (eq_w[1]), .gt (gt_w[1]), .lt (lt_w[1])
  );

  function automatic logic [2:0] exp_res(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input bit early);
    int dx, dy;
    if (!early) return D;
    for (int i = D - 1; i >= 0; i--) begin
      dx = (int'(x) / (4 ** i)) % 4;
      dy = (int'(y) / (4 ** i)) % 4;
      if (dx != dy) return D - i;
    end
    return D;
  endfunction

  task automatic watch(input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input bit poke);
    int first[2];
    int ndone[2];
    int nbusy[2];
    int k;
    logic [2:0] r;
    for (int d = 0; d < 2; d++) begin
      first[d] = -1; ndone[d] = 0; nbusy[d] = 0;
    end
    for (int c = 0; c <= D + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        for (int d = 0; d < 2; d++) begin
          vectors++;
          if ({busy_w[d], eq_w[d], gt_w[d], lt_w[d]} !== 4'b1000) begin
            miscompares++;
            $display("FAIL accept_clear dut%0d busy/eq/gt/lt=%b%b%b%b want 1000",
                     d, busy_w[d], eq_w[d], gt_w[d], lt_w[d]);
          end
        end
      end
      if (poke && c == 1) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end
      if (poke && c == 2) start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (busy_w[d]) nbusy[d]++;
        if (done_w[d]) begin
          ndone[d]++;
          if (first[d] < 0) first[d] = c;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      k = exp_lat(ea, eb, d == 0);
      r = exp_res(ea, eb);
      vectors++;
      if (first[d] != k) begin
        miscompares++;
        $display("FAIL latency dut%0d a=%h b=%h got %0d want %0d",
                 d, ea, eb, first[d], k);
      end
      vectors++;
      if (ndone[d] != 1) begin
        miscompares++;
        $display("FAIL done_pulse dut%0d a=%h b=%h got %0d cycles want 1",
                 d, ea, eb, ndone[d]);
      end
      vectors++;
      if (nbusy[d] != k) begin
        miscompares++;
        $display("FAIL busy_len dut%0d a=%h b=%h got %0d want %0d",
                 d, ea, eb, nbusy[d], k);
      end
      vectors++;
      if ({eq_w[d], gt_w[d], lt_w[d]} !== r) begin
        miscompares++;
        $display("FAIL result dut%0d a=%h b=%h eq/gt/lt got %b%b%b want %b",
                 d, ea, eb, eq_w[d], gt_w[d], lt_w[d], r);
      end
    end
  endtask

  task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    watch(x, y, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy_w, done_w, eq_w, gt_w, lt_w} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 0",
               {busy_w, done_w, eq_w, gt_w, lt_w});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy_w, done_w, eq_w, gt_w, lt_w} !== 10'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset got %b want 0",
               {busy_w, done_w, eq_w, gt_w, lt_w});
    end
  endtask

  task automatic test_directed;
    run_cmp(8'hA5, 8'hA5);
    run_cmp(8'h80, 8'h7F);
    run_cmp(8'h12, 8'h13);
    run_cmp(8'h00, 8'hFF);
    run_cmp(8'h4C, 8'h4D);
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      case ($urandom_range(0, 2))
        0:       y = x;
        1:       y = W'($urandom);
        default: y = x ^ W'(1 << $urandom_range(0, W - 1));
      endcase
      run_cmp(x, y);
    end
  endtask

  task automatic test_busy_ignore;
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(posedge clk);
    #1 start = 1'b0;
    watch(8'h01, 8'h02, 1'b1);
  endtask

  task automatic test_reset_abort;
    int nd, nb;
    start = 1'b1; a = 8'h55; b = 8'h56;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy_w, done_w, eq_w, gt_w, lt_w} !== 10'b0) begin
      miscompares++;
      $display("FAIL abort_outputs got %b want 0",
               {busy_w, done_w, eq_w, gt_w, lt_w});
    end
    nd = 0; nb = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nd += int'(done_w[0]) + int'(done_w[1]);
      nb += int'(busy_w[0]) + int'(busy_w[1]);
    end
    vectors++;
    if (nd != 0 || nb != 0) begin
      miscompares++;
      $display("FAIL abort_no_done done=%0d busy=%0d want 0 0", nd, nb);
    end
    run_cmp(8'hC3, 8'hC3);
  endtask

  task automatic test_back_to_back;
    start = 1'b1; a = 8'h33; b = 8'h33;
    @(posedge clk);
    for (int c = 0; c <= D; c++) @(negedge clk);
    vectors++;
    if ({done_w, eq_w} !== 4'b1111) begin
      miscompares++;
      $display("FAIL b2b_first done=%b eq=%b want 11 11", done_w, eq_w);
    end
    a = 8'h40; b = 8'h30;
    @(posedge clk);
    #1 start = 1'b0;
    watch(8'h40, 8'h30, 1'b0);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_busy_ignore;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
